// File: rtl/spi_pkg.sv
// SPI master shared definitions.
// FSM state encoding and mode-bit positions.
package spi_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SETUP = 2'd1;
  localparam state_t XFER  = 2'd2;
  localparam state_t HOLD  = 2'd3;

  localparam int CPOL = 1;
  localparam int CPHA = 0;

endpackage

// File: rtl/spi_clkgen.sv
// SPI half-period timer.
// Emits a one-clock tick every div+1 clocks while running.
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (load) begin
      div_d = div;
      cnt_d = div;
    end else if (run) begin
      cnt_d = (cnt_q == '0) ? div_q : cnt_q - 1'b1;
    end
  end

  assign tick = run && (cnt_q == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master: configurable width, divisor, mode and bit order.
// All bus outputs come straight from flops.
module spi_master
  import spi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8,
  parameter int NCS   = 2,
  localparam int CSW  = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] din,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       mode,
  input  logic             lsb_first,
  input  logic [CSW-1:0]   cs_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             sck,
  output logic             mosi,
  output logic [NCS-1:0]   cs_n,
  input  logic             miso
);

  localparam int TW = $clog2(2 * WIDTH) + 1;

  state_t           state_q, state_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic [NCS-1:0]   cs_n_q, cs_n_d;
  logic [1:0]       mode_q, mode_d;
  logic             lsb_q, lsb_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             done_q, done_d;

  logic tick;
  logic accept;
  logic lead;
  logic first;
  logic last;
  logic smp;
  logic adv;

  function automatic logic [NCS-1:0] cs_decode(
    input logic [CSW-1:0] sel
  );
    logic [NCS-1:0] r;
    r = '1;
    for (int i = 0; i < NCS; i++) begin
      if (CSW'(i) == sel) r[i] = 1'b0;
    end
    return r;
  endfunction

  assign busy   = (state_q != IDLE);
  assign accept = (state_q == IDLE) && start && !abort;

  // Toggle number is tcnt_q+1; odd toggles are leading edges.
  assign lead  = ~tcnt_q[0];
  assign first = (tcnt_q == '0);
  assign last  = (tcnt_q == TW'(2 * WIDTH - 1));
  assign smp   = mode_q[CPHA] ? ~lead : lead;
  assign adv   = mode_q[CPHA] ? (lead & ~first) : (~lead & ~last);

  spi_clkgen #(
    .DIV_W(DIV_W)
  ) u_clkgen (
    .clock(clock),
    .reset(reset),
    .load (accept),
    .run  (busy),
    .div  (div),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    mode_d  = mode_q;
    lsb_d   = lsb_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    tcnt_d  = tcnt_q;
    done_d  = 1'b0;
    if (busy && abort) begin
      state_d = IDLE;
      cs_n_d  = '1;
      sck_d   = mode_q[CPOL];
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = SETUP;
            mode_d  = mode;
            lsb_d   = lsb_first;
            tx_d    = din;
            tcnt_d  = '0;
            sck_d   = mode[CPOL];
            mosi_d  = lsb_first ? din[0] : din[WIDTH-1];
            cs_n_d  = cs_decode(cs_sel);
          end
        end
        SETUP: begin
          if (tick) state_d = XFER;
        end
        XFER: begin
          if (tick) begin
            sck_d  = ~sck_q;
            tcnt_d = tcnt_q + 1'b1;
            if (smp) begin
              rx_d = lsb_q ? {miso, rx_q[WIDTH-1:1]}
                           : {rx_q[WIDTH-2:0], miso};
            end
            if (adv) begin
              tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
              mosi_d = lsb_q ? tx_q[1] : tx_q[WIDTH-2];
            end
            if (last) state_d = HOLD;
          end
        end
        HOLD: begin
          if (tick) begin
            state_d = IDLE;
            cs_n_d  = '1;
            dout_d  = rx_q;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= '1;
      mode_q  <= 2'b00;
      lsb_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      tcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      mode_q  <= mode_d;
      lsb_q   <= lsb_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      tcnt_q  <= tcnt_d;
      done_q  <= done_d;
    end
  end

  assign sck  = sck_q;
  assign mosi = mosi_q;
  assign cs_n = cs_n_q;
  assign dout = dout_q;
  assign done = done_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master with a mode-aware SPI slave model.
// Expected words and latencies are queued at issue, checked on done.
module tb_spi_master;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] div = 8'h00;
  logic [1:0] mode = 2'b00;
  logic       lsb_first = 1'b0;
  logic [0:0] cs_sel = 1'b0;
  logic       miso = 1'b0;
  logic       busy, done, sck, mosi;
  logic [7:0] dout;
  logic [1:0] cs_n;

  spi_master #(.WIDTH(8), .DIV_W(8), .NCS(2)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .din(din), .div(div), .mode(mode), .lsb_first(lsb_first),
    .cs_sel(cs_sel), .busy(busy), .done(done), .dout(dout),
    .sck(sck), .mosi(mosi), .cs_n(cs_n), .miso(miso)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] dout;
    logic [7:0] tx;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_done = 0;

  logic [7:0] sl_word = 8'h00;
  logic [7:0] sl_rx = 8'h00;
  logic [1:0] sl_mode = 2'b00;
  logic       sl_lsb = 1'b0;
  logic       sl_err = 1'b0;
  int         sl_ecnt = 0;
  int         sl_bit = 0;
  logic       sl_act_q = 1'b0;
  logic       sl_sck_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sbit(input int i);
    return sl_lsb ? sl_word[i] : sl_word[7-i];
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Slave: checks sck level at leading edges, samples mosi, drives miso.
  always @(negedge clock) begin
    logic act;
    logic lead;
    act = (cs_n != 2'b11);
    if (act && !sl_act_q) begin
      sl_ecnt = 0;
      sl_rx   = 8'h00;
      sl_err  = 1'b0;
      sl_bit  = 0;
      if (sck !== sl_mode[1]) sl_err = 1'b1;
      if (!sl_mode[0]) miso = sbit(0);
    end else if (act && sck != sl_sck_q) begin
      sl_ecnt++;
      lead = sl_ecnt[0];
      if (lead && sck !== ~sl_mode[1]) sl_err = 1'b1;
      if (lead != sl_mode[0]) begin
        sl_rx = sl_lsb ? {mosi, sl_rx[7:1]} : {sl_rx[6:0], mosi};
      end else if (sl_mode[0]) begin
        if (sl_bit < 8) miso = sbit(sl_bit);
        sl_bit++;
      end else begin
        sl_bit++;
        if (sl_bit < 8) miso = sbit(sl_bit);
      end
    end
    sl_act_q = act;
    sl_sck_q = sck;
  end

  // Monitor: pops the scoreboard on each done pulse.
  always @(negedge clock) begin
    if (!reset) begin
      if (done) begin
        n_done++;
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected none");
        end else begin
          exp_t e;
          int   a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("dout", dout, e.dout);
          chk("slave_rx", sl_rx, e.tx);
          chk("latency", cyc - a, e.lat);
          chk("slave_err", sl_err, 0);
          chk("sck_edges", sl_ecnt, 16);
        end
      end
      if (start && !busy && !abort) begin
        acc_q.push_back(cyc + 1);
        n_acc++;
      end
    end
  end

  task automatic issue(input logic [7:0] d, input logic [7:0] dv,
                       input logic [1:0] m, input logic l,
                       input logic c, input logic [7:0] sw,
                       input bit track);
    sl_word = sw;
    sl_mode = m;
    sl_lsb  = l;
    if (track) exp_q.push_back('{sw, d, 18 * (int'(dv) + 1)});
    @(posedge clock); #1;
    din = d; div = dv; mode = m; lsb_first = l; cs_sel = c;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    din = ~d; div = 8'd9; mode = ~m; lsb_first = ~l; cs_sel = ~c;
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: pending=%0d expected 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
    repeat (2) @(posedge clock);
  endtask

  initial begin
    int d0;
    int a0;
    int k;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_cs_n", cs_n, 2'b11);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);

    issue(8'hA5, 8'd0, 2'd0, 1'b0, 1'b0, 8'h3C, 1);
    wait_empty(500);

    issue(8'h01, 8'd3, 2'd3, 1'b1, 1'b1, 8'h96, 1);
    chk("m3_cs_n", cs_n, 2'b01);
    chk("m3_sck_setup", sck, 1);
    chk("m3_mosi_first", mosi, 1);
    chk("m3_busy", busy, 1);
    wait_empty(500);
    chk("m3_sck_idle", sck, 1);
    chk("m3_cs_idle", cs_n, 2'b11);

    issue(8'h5A, 8'd1, 2'd1, 1'b0, 1'b0, 8'hC3, 1);
    wait_empty(500);
    issue(8'h3C, 8'd2, 2'd2, 1'b1, 1'b0, 8'h81, 1);
    wait_empty(500);

    d0 = n_done;
    issue(8'hFF, 8'd0, 2'd0, 1'b0, 1'b0, 8'h12, 0);
    repeat (6) @(posedge clock);
    #1 abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_cs_n", cs_n, 2'b11);
    chk("abort_sck", sck, 0);
    chk("abort_dout", dout, 8'h81);
    acc_q.delete();
    repeat (25) @(posedge clock);
    chk("abort_no_done", n_done - d0, 0);

    d0 = n_done;
    a0 = n_acc;
    sl_word = 8'hD2;
    sl_mode = 2'd0;
    sl_lsb  = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back('{8'hD2, 8'h6B, 18});
    @(posedge clock); #1;
    din = 8'h6B; div = 8'd0; mode = 2'd0; lsb_first = 1'b0;
    cs_sel = 1'b0; start = 1'b1;
    k = 0;
    while (n_acc < a0 + 3 && k < 200) begin
      @(negedge clock);
      k++;
    end
    @(posedge clock); #1;
    start = 1'b0;
    wait_empty(500);
    repeat (20) @(posedge clock);
    chk("b2b_done_cnt", n_done - d0, 3);
    chk("b2b_acc_cnt", n_acc - a0, 3);

    d0 = n_done;
    issue(8'hC7, 8'd1, 2'd0, 1'b0, 1'b0, 8'h5E, 1);
    repeat (10) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_dout", dout, 8'h00);
    chk("mid_rst_cs_n", cs_n, 2'b11);
    chk("mid_rst_sck", sck, 0);
    chk("mid_rst_mosi", mosi, 0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    chk("mid_rst_no_done", n_done - d0, 0);
    issue(8'h11, 8'd0, 2'd0, 1'b0, 1'b0, 8'hEE, 1);
    wait_empty(500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter WIDTH, default 8, bits per transfer (2..32).
REQ-002 Parameter DIV_W, default 8, width of the half-period divisor input.
REQ-003 Parameter NCS, default 2, number of chip-select outputs (1..8).
REQ-004 clock  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  transfer request; honoured only in IDLE.
REQ-007 abort  input  1  terminate the current transfer immediately.
REQ-008 din  input  WIDTH  transmit word, latched on start accept.
REQ-009 div  input  DIV_W  half-period = div+1 clocks, latched on start accept.
REQ-010 mode  input  2  {CPOL,CPHA}, latched on start accept.
REQ-011 lsb_first  input  1  1 = shift LSB first, latched on start accept.
REQ-012 cs_sel  input  max(1,$clog2(NCS))  chip-select index, latched on start accept.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse on normal completion.
REQ-015 dout  output  WIDTH  received word; updated only on completion.
REQ-016 sck, mosi, cs_n  output  1,1,NCS  SPI bus; cs_n active-low.
REQ-017 miso  input  1  SPI serial data in.

Function
REQ-018 The FSM SHALL have states IDLE, SETUP, XFER, HOLD; each non-IDLE phase is timed in half-periods of div+1 clocks.
REQ-019 IDLE: start=1 and abort=0 at a rising edge SHALL latch din/div/mode/lsb_first/cs_sel, drive cs_n[cs_sel] low and enter SETUP.
REQ-020 SETUP SHALL last one half-period with sck=CPOL and mosi = first data bit, then enter XFER.
REQ-021 XFER SHALL produce 2*WIDTH sck toggles, one per half-period, starting from CPOL.
REQ-022 CPHA=0: miso SHALL be sampled on odd toggles (leading edges); mosi SHALL advance on even toggles except the last.
REQ-023 CPHA=1: mosi SHALL advance on odd toggles except the first; miso SHALL be sampled on even toggles.
REQ-024 Bit order SHALL follow lsb_first for both mosi and the receive shift register.
REQ-025 HOLD SHALL last one half-period with sck=CPOL and cs_n still asserted, then return to IDLE.
REQ-026 On HOLD exit, cs_n SHALL return to all-ones, dout SHALL load the received word, and done SHALL pulse for exactly one clock.
REQ-027 The start-accept edge to the done pulse SHALL span exactly (2*WIDTH+2)*(div+1) clock cycles.
REQ-028 start while busy SHALL be ignored; start in the cycle done is high SHALL be accepted (back-to-back).
REQ-029 abort in a non-IDLE state SHALL, at the next edge, force IDLE, cs_n all-ones and sck=CPOL, without done and without changing dout.
REQ-030 abort and start together in IDLE SHALL ignore start.
REQ-031 Changes to div, mode, din or cs_sel during a transfer SHALL have no effect on that transfer.
REQ-032 div=0 SHALL be legal: one clock per half-period, sck = clock/2.
REQ-033 An out-of-range cs_sel (>= NCS) SHALL run the transfer with no cs_n asserted.
REQ-034 sck, mosi and cs_n SHALL be driven directly from registers (glitch-free).

Reset
REQ-035 Reset SHALL force IDLE, with busy=0, done=0, dout=0, cs_n all-ones, sck=0, mosi=0, and latched mode=0.
REQ-036 Reset mid-transfer SHALL behave as REQ-035 immediately (asynchronously), with no done pulse.

Structure
REQ-037 Shared package spi_pkg SHALL hold the state enum (IDLE, SETUP, XFER, HOLD) and the mode bit index constants (CPOL=1, CPHA=0).
REQ-038 Sub-module spi_clkgen SHALL hold the half-period down-counter and emit a one-clock tick per half-period; it is reloaded on start accept.

Verification
REQ-039 Mode 0, WIDTH=8, div=0, din=0xA5, slave returns 0x3C MSB-first: mosi bits 1,0,1,0,0,1,0,1; dout=0x3C; done exactly 18 cycles after accept.
REQ-040 Mode 3, div=3, lsb_first=1, din=0x01, cs_sel=1: cs_n=2'b01 during the transfer; sck idles high; first mosi bit=1; done at 72 cycles.
REQ-041 Modes 1 and 2 against a slave model that checks sample edges: no slave error and dout matches the slave word.
REQ-042 abort at cycle 7 of a div=0 transfer: IDLE next cycle, cs_n=2'b11, done never asserted, dout unchanged.
REQ-043 start held high continuously for 3 words: three done pulses, each accept in the done cycle; start while busy ignored.
REQ-044 Reset asserted mid-XFER: all outputs reach reset values with no clock edge; a subsequent transfer completes normally.
